slink_apb_cmd_master: RTL and testbench
=======================================

Name: slink_apb_cmd_master

Overview:
- Synthesizable, parametrised APB master: the hardware successor to the bench-only APB write/read tasks.
- Accepts queued write/read/poll commands over a valid/ready interface and executes them as APB transfers, back-to-back.
- Each command returns exactly one response (read data plus status) through a response FIFO.
- Adds capabilities the bench tasks lack: command queuing, wait-state timeout, PSLVERR reporting, hardware register polling.
- Used in bench and bring-up fabrics to drive link/app register blocks without CPU involvement.

Parameters:
- APB_ADDR_WIDTH, 32: paddr/cmd_addr width.
- APB_DATA_WIDTH, 32: pwdata/prdata width.
- CMD_DEPTH, 4: command FIFO entries (power of 2, ≥2).
- RSP_DEPTH, 4: response FIFO entries (power of 2, ≥2).
- TIMEOUT_CYCLES, 256: maximum ACCESS cycles before abort (≥2).
- POLL_MAX, 1024: maximum reads per poll command (≥1).

Ports:
- apb_clk  in  1  single clock for the whole block.
- apb_reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command FIFO not full.
- cmd_op  in  2  00 write, 01 read, 10 poll, 11 reserved (treated as read).
- cmd_addr  in  APB_ADDR_WIDTH  target address.
- cmd_wdata  in  APB_DATA_WIDTH  write data (write) / expected value (poll).
- cmd_mask  in  APB_DATA_WIDTH  poll compare mask; ignored for other ops.
- rsp_valid  out  1  response FIFO not empty.
- rsp_ready  in  1  consumer pops response.
- rsp_rdata  out  APB_DATA_WIDTH  read data; 0 for writes; last read value for poll.
- rsp_status  out  2  00 OK, 01 SLVERR, 10 TIMEOUT, 11 POLL_FAIL.
- busy  out  1  state≠IDLE or command FIFO non-empty.
- apb_paddr  out  APB_ADDR_WIDTH
- apb_pwrite  out  1
- apb_psel  out  1
- apb_penable  out  1
- apb_pwdata  out  APB_DATA_WIDTH
- apb_prdata  in  APB_DATA_WIDTH
- apb_pready  in  1
- apb_pslverr  in  1

Behaviour:
- Reset (synchronous, takes effect at the clock edge):
  - All outputs 0 except cmd_ready=1; both FIFOs empty; state IDLE; counters 0.
  - Reset mid-transfer: psel/penable low after the reset edge; the in-flight command and all queued commands are discarded with no response.
- Command FIFO:
  - Push on cmd_valid&&cmd_ready.
  - cmd_ready depends only on registered full; no same-cycle pop pass-through.
- FSM states: IDLE, SETUP, ACCESS, GAP.
- Start condition: cmd FIFO non-empty AND ≥1 free response slot, counting this cycle's push/pop.
- IDLE → SETUP when the start condition holds; pops the command. SETUP drives psel=1, penable=0, paddr, pwrite (op==00), pwdata.
- SETUP → ACCESS unconditionally; penable=1. All APB outputs are held stable through ACCESS.
- ACCESS with pready=1 (completion):
  - Write/read: push response with rdata (prdata for read, 0 for write) and status (SLVERR if pslverr, else OK).
  - Poll, pslverr=1: push rdata with SLVERR.
  - Poll, (prdata&mask)==(wdata&mask): push rdata with OK.
  - Poll, mismatch and poll count == POLL_MAX: push last rdata with POLL_FAIL.
  - Poll, otherwise: count++, go to GAP.
  - After any push: go to SETUP if the start condition holds (psel stays 1, penable 0, next command popped); else go to IDLE (psel 0).
- ACCESS with pready=0: wait-counter++. If the counter reaches TIMEOUT_CYCLES, abort: psel/penable drop next edge, push rdata=0 with TIMEOUT, go to IDLE.
  - The abort is an intentional APB protocol violation, used for hang detection.
- Timers: wait-counter clears on every SETUP. Poll counter clears when a poll command starts, and counts reads performed.
- GAP: one cycle with psel=0, then SETUP re-reads the same address.
- Latency:
  - cmd accepted at edge N → psel=1 after edge N+1, penable=1 after N+2.
  - With zero wait states, pready is sampled at N+3 and rsp_valid=1 after N+3.
  - Steady back-to-back throughput: one transfer per 2 cycles.
- Response FIFO: simultaneous push and pop allowed when full. rsp_rdata/rsp_status reflect the head entry.
- A response is never dropped: the start condition guarantees space. If the response FIFO is full, the FSM waits in IDLE.

Test Plan:
- Write 0x10←0xDEADBEEF with pready tied 1 → psel one cycle before penable; transfer completes at edge N+3; response rdata=0, status=00.
- Read 0x24 with 3 wait states and prdata=0x1234_5678 → ACCESS lasts 4 cycles with stable paddr; response 0x12345678/00. Same read with pslverr=1 → status=01.
- TIMEOUT_CYCLES=16, pready held 0 → psel drops after exactly 16 ACCESS cycles; response rdata=0/10; next queued command then executes normally.
- Poll addr 0x8, mask 0x1, expect 0x1; slave returns 0,0,1 → three transfers separated by GAP cycles, one response 0x1/00. With POLL_MAX=4 and slave always 0 → four reads, response 0x0/11.
- Push 8 reads with rsp_ready=0 (CMD_DEPTH=RSP_DEPTH=4) → cmd_ready drops when full; exactly 4 transfers execute and then stall in IDLE; releasing rsp_ready yields 8 in-order responses.
- Assert apb_reset during ACCESS with 2 commands queued → next edge psel=penable=0, busy=0, rsp_valid=0, cmd_ready=1; no responses emitted.

Source files
------------

// File: rtl/slink_apb_cmd_master.sv
// rtl/slink_apb_cmd_master.sv - queued APB master running write/read/poll commands
// Command and response queues are local FIFOs; one FSM sequences IDLE/SETUP/ACCESS/GAP.

module slink_apb_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full queue is accepted only when the head leaves in the same cycle.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != FULL) || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end
endmodule

module slink_apb_cmd_master #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int RSP_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int POLL_MAX       = 1024
) (
  input  logic                      apb_clk,
  input  logic                      apb_reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
  input  logic [APB_DATA_WIDTH-1:0] cmd_mask,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                rsp_status,
  output logic                      busy,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr,
  output logic                      apb_pwrite,
  output logic                      apb_psel,
  output logic                      apb_penable,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata,
  input  logic [APB_DATA_WIDTH-1:0] apb_prdata,
  input  logic                      apb_pready,
  input  logic                      apb_pslverr
);
  localparam int CMD_W  = 2 + APB_ADDR_WIDTH + 2 * APB_DATA_WIDTH;
  localparam int RSP_W  = APB_DATA_WIDTH + 2;
  localparam int CCW    = $clog2(CMD_DEPTH + 1);
  localparam int RCW    = $clog2(RSP_DEPTH + 1);
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int POLL_W = $clog2(POLL_MAX + 1);

  localparam logic [CCW-1:0]    CMD_FULL  = CCW'(CMD_DEPTH);
  localparam logic [RCW:0]      RSP_FULL  = (RCW + 1)'(RSP_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);

  localparam logic [1:0] OP_WRITE     = 2'b00;
  localparam logic [1:0] OP_POLL      = 2'b10;
  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_SLVERR    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT   = 2'b10;
  localparam logic [1:0] ST_POLL_FAIL = 2'b11;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, GAP} state_t;

  state_t state;
  state_t state_next;

  logic [CCW-1:0]            cmd_count;
  logic [CMD_W-1:0]          cmd_head;
  logic                      cmd_push;
  logic                      cmd_pop;
  logic [1:0]                head_op;
  logic [APB_ADDR_WIDTH-1:0] head_addr;
  logic [APB_DATA_WIDTH-1:0] head_wdata;
  logic [APB_DATA_WIDTH-1:0] head_mask;

  logic [1:0]                cur_op;
  logic                      cur_write;
  logic [APB_ADDR_WIDTH-1:0] cur_addr;
  logic [APB_DATA_WIDTH-1:0] cur_wdata;
  logic [APB_DATA_WIDTH-1:0] cur_mask;
  logic [WAIT_W-1:0]         wait_cnt;
  logic [POLL_W-1:0]         poll_cnt;

  logic [RCW-1:0]            rsp_count;
  logic [RSP_W-1:0]          rsp_head;
  logic                      rsp_push;
  logic                      rsp_pop;
  logic [APB_DATA_WIDTH-1:0] rsp_push_rdata;
  logic [1:0]                rsp_push_status;
  logic [RCW:0]              rsp_cnt_next;

  logic access_done;
  logic timeout_hit;
  logic poll_match;
  logic poll_again;
  logic xfer_done;
  logic start;

  assign cmd_ready = (cmd_count != CMD_FULL);
  assign cmd_push  = cmd_valid && cmd_ready;

  slink_apb_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (apb_clk),
    .reset     (apb_reset),
    .push      (cmd_push),
    .push_data ({cmd_op, cmd_addr, cmd_wdata, cmd_mask}),
    .pop       (cmd_pop),
    .head      (cmd_head),
    .count     (cmd_count)
  );

  assign {head_op, head_addr, head_wdata, head_mask} = cmd_head;

  slink_apb_cmd_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk       (apb_clk),
    .reset     (apb_reset),
    .push      (rsp_push),
    .push_data ({rsp_push_rdata, rsp_push_status}),
    .pop       (rsp_pop),
    .head      (rsp_head),
    .count     (rsp_count)
  );

  assign rsp_valid  = (rsp_count != '0);
  assign rsp_pop    = rsp_valid && rsp_ready;
  assign rsp_rdata  = rsp_valid ? rsp_head[RSP_W-1:2] : '0;
  assign rsp_status = rsp_valid ? rsp_head[1:0] : '0;

  assign access_done = (state == ACCESS) && apb_pready;
  assign timeout_hit = (state == ACCESS) && !apb_pready && (wait_cnt == WAIT_LAST);
  assign poll_match  = ((apb_prdata ^ cur_wdata) & cur_mask) == '0;
  assign poll_again  = access_done && (cur_op == OP_POLL) && !apb_pslverr &&
                       !poll_match && (poll_cnt != POLL_LAST);
  assign xfer_done   = access_done && !poll_again;
  assign rsp_push    = xfer_done || timeout_hit;

  // Free-slot test sees this cycle's push and pop, so a response always has room.
  assign rsp_cnt_next = {1'b0, rsp_count} + {{RCW{1'b0}}, rsp_push} - {{RCW{1'b0}}, rsp_pop};
  assign start        = (cmd_count != '0) && (rsp_cnt_next < RSP_FULL);

  always_comb begin
    rsp_push_status = ST_OK;
    rsp_push_rdata  = cur_write ? '0 : apb_prdata;
    if (timeout_hit) begin
      rsp_push_status = ST_TIMEOUT;
      rsp_push_rdata  = '0;
    end else if (apb_pslverr) begin
      rsp_push_status = ST_SLVERR;
    end else if ((cur_op == OP_POLL) && !poll_match) begin
      rsp_push_status = ST_POLL_FAIL;
    end
  end

  always_ff @(posedge apb_clk) begin
    if (apb_reset) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS: begin
        if (timeout_hit)     state_next = IDLE;
        else if (poll_again) state_next = GAP;
        else if (xfer_done)  state_next = start ? SETUP : IDLE;
      end
      GAP:     state_next = SETUP;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    apb_psel    = 1'b0;
    apb_penable = 1'b0;
    cmd_pop     = 1'b0;
    case (state)
      IDLE:   cmd_pop = start;
      SETUP:  apb_psel = 1'b1;
      ACCESS: begin
        apb_psel    = 1'b1;
        apb_penable = 1'b1;
        cmd_pop     = xfer_done && start;
      end
      default: ;
    endcase
  end

  always_ff @(posedge apb_clk) begin
    if (apb_reset) begin
      cur_op    <= '0;
      cur_write <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      cur_mask  <= '0;
      wait_cnt  <= '0;
      poll_cnt  <= '0;
    end else begin
      if (cmd_pop) begin
        cur_op    <= head_op;
        cur_write <= (head_op == OP_WRITE);
        cur_addr  <= head_addr;
        cur_wdata <= head_wdata;
        cur_mask  <= head_mask;
        poll_cnt  <= '0;
      end else if (poll_again) begin
        poll_cnt  <= poll_cnt + 1'b1;
      end
      if (state == SETUP)                    wait_cnt <= '0;
      else if (state == ACCESS && !apb_pready) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign apb_paddr  = cur_addr;
  assign apb_pwdata = cur_wdata;
  assign apb_pwrite = cur_write;
  assign busy       = (state != IDLE) || (cmd_count != '0);
endmodule

// File: tb/tb_slink_apb_cmd_master.sv
// tb/tb_slink_apb_cmd_master.sv - self-checking bench for slink_apb_cmd_master
// Table-driven command vectors plus hand sequences; a scoreboard queue holds expected responses.

module tb_slink_apb_cmd_master;
  logic        apb_clk;
  logic        apb_reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] cmd_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic        busy;
  logic [31:0] apb_paddr;
  logic        apb_pwrite;
  logic        apb_psel;
  logic        apb_penable;
  logic [31:0] apb_pwdata;
  logic [31:0] apb_prdata;
  logic        apb_pready;
  logic        apb_pslverr;

  slink_apb_cmd_master #(
    .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .CMD_DEPTH(4), .RSP_DEPTH(4),
    .TIMEOUT_CYCLES(16), .POLL_MAX(4)
  ) dut (
    .apb_clk(apb_clk), .apb_reset(apb_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status), .busy(busy),
    .apb_paddr(apb_paddr), .apb_pwrite(apb_pwrite), .apb_psel(apb_psel),
    .apb_penable(apb_penable), .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata),
    .apb_pready(apb_pready), .apb_pslverr(apb_pslverr)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  status;
  } exp_t;

  typedef struct {
    int          waits;
    logic [31:0] prdata;
    logic        err;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } cfg_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mask;
    int          waits;
    logic [31:0] prdata;
    logic        err;
    logic [31:0] er;
    logic [1:0]  es;
  } vec_t;

  exp_t exp_q[$];
  cfg_t cfg_q[$];
  int   len_q[$];
  cfg_t cur_cfg;
  exp_t got_exp;
  vec_t vecs[7];

  int n_pass = 0;
  int n_total = 0;
  int xfer_cnt = 0;
  int idle_busy = 0;
  int rsp_seen = 0;
  int acc_k = 0;
  logic addr_stable;

  initial begin
    apb_clk = 1'b0;
    forever #5 apb_clk = ~apb_clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Slave model and transfer monitor, evaluated mid-cycle.
  always @(negedge apb_clk) begin
    if (apb_psel && apb_penable && !apb_reset) begin
      if (acc_k == 0) begin
        if (cfg_q.size() > 0) cur_cfg = cfg_q.pop_front();
        else cur_cfg = '{waits: 0, prdata: 32'h0, err: 1'b0, addr: 32'h0, write: 1'b0, wdata: 32'h0};
        addr_stable = 1'b1;
      end
      if (apb_paddr !== cur_cfg.addr) addr_stable = 1'b0;
      acc_k++;
      if (acc_k > cur_cfg.waits) begin
        apb_pready  = 1'b1;
        apb_prdata  = cur_cfg.prdata;
        apb_pslverr = cur_cfg.err;
        xfer_cnt++;
        chk("paddr_stable", addr_stable, 1'b1);
        chk("pwrite", apb_pwrite, cur_cfg.write);
        if (cur_cfg.write) chk("pwdata", apb_pwdata, cur_cfg.wdata);
      end else begin
        apb_pready  = 1'b0;
        apb_prdata  = 32'h0;
        apb_pslverr = 1'b0;
      end
    end else begin
      if (acc_k > 0) len_q.push_back(acc_k);
      acc_k       = 0;
      apb_pready  = 1'b0;
      apb_prdata  = 32'h0;
      apb_pslverr = 1'b0;
      if (!apb_psel && busy && !apb_reset) idle_busy++;
    end
  end

  // Response consumer: the handshake completes on the following rising edge.
  always @(negedge apb_clk) begin
    if (!apb_reset && rsp_valid && rsp_ready) begin
      rsp_seen++;
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", rsp_valid, 1'b0);
      end else begin
        got_exp = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, got_exp.rdata);
        chk("rsp_status", rsp_status, got_exp.status);
      end
    end
  end

  task automatic push_cfg(input int waits, input logic [31:0] prdata, input logic err,
                          input logic [31:0] addr, input logic write, input logic [31:0] wdata);
    cfg_t c;
    c.waits = waits; c.prdata = prdata; c.err = err;
    c.addr = addr; c.write = write; c.wdata = wdata;
    cfg_q.push_back(c);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] mask, input logic [31:0] er, input logic [1:0] es);
    int n = 0;
    exp_t e;
    cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; cmd_mask = mask;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(posedge apb_clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_accept", cmd_ready, 1'b1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge apb_clk);
    e.rdata = er; e.status = es;
    exp_q.push_back(e);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max) begin
      @(posedge apb_clk); #1;
      n++;
    end
    chk("drain_done", {exp_q.size() == 0, busy}, 2'b10);
    repeat (2) @(posedge apb_clk);
    #1;
  endtask

  function automatic int len_at(input int i);
    return (len_q.size() > i) ? len_q[i] : -1;
  endfunction

  initial begin
    int x0;
    int n;
    apb_reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 2'b00; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_mask = 32'h0;
    apb_pready = 1'b0; apb_prdata = 32'h0; apb_pslverr = 1'b0;

    vecs[0] = '{2'b00, 32'h100, 32'hA5A5_0001, 32'h0,      0, 32'h0,         1'b0, 32'h0,         2'b00};
    vecs[1] = '{2'b01, 32'h104, 32'h0,         32'h0,      2, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 2'b00};
    vecs[2] = '{2'b01, 32'h024, 32'h0,         32'h0,      3, 32'h1234_5678, 1'b1, 32'h1234_5678, 2'b01};
    vecs[3] = '{2'b00, 32'h108, 32'h0000_0077, 32'h0,      1, 32'h0,         1'b1, 32'h0,         2'b01};
    vecs[4] = '{2'b11, 32'h10C, 32'h0,         32'h0,      0, 32'h0BAD_C0DE, 1'b0, 32'h0BAD_C0DE, 2'b00};
    vecs[5] = '{2'b10, 32'h110, 32'h0000_1200, 32'hFF00,   1, 32'h0000_12AB, 1'b0, 32'h0000_12AB, 2'b00};
    vecs[6] = '{2'b10, 32'h114, 32'h1,         32'h1,      0, 32'h0000_0006, 1'b1, 32'h0000_0006, 2'b01};

    repeat (3) @(posedge apb_clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_psel", {apb_psel, apb_penable, apb_pwrite}, 3'b000);
    chk("rst_paddr", apb_paddr, 32'h0);
    chk("rst_pwdata", apb_pwdata, 32'h0);
    chk("rst_rsp", {rsp_rdata, rsp_status}, 34'h0);
    apb_reset = 1'b0;
    @(posedge apb_clk); #1;

    // Latency of a single zero-wait write.
    push_cfg(0, 32'h0, 1'b0, 32'h10, 1'b1, 32'hDEAD_BEEF);
    send_cmd(2'b00, 32'h10, 32'hDEAD_BEEF, 32'h0, 32'h0, 2'b00);
    chk("lat_n0_psel", apb_psel, 1'b0);
    @(posedge apb_clk); #1;
    chk("lat_n1_sel_en", {apb_psel, apb_penable}, 2'b10);
    chk("lat_n1_paddr", apb_paddr, 32'h10);
    chk("lat_n1_pwdata", apb_pwdata, 32'hDEAD_BEEF);
    @(posedge apb_clk); #1;
    chk("lat_n2_sel_en", {apb_psel, apb_penable}, 2'b11);
    chk("lat_n2_rsp_valid", rsp_valid, 1'b0);
    @(posedge apb_clk); #1;
    chk("lat_n3_rsp_valid", rsp_valid, 1'b1);
    chk("lat_n3_psel", apb_psel, 1'b0);
    chk("lat_n3_rsp", {rsp_rdata, rsp_status}, 34'h0);
    rsp_ready = 1'b1;
    drain(50);

    // Table of single-transfer commands, issued back to back.
    len_q.delete();
    for (int i = 0; i < 7; i++) begin
      push_cfg(vecs[i].waits, vecs[i].prdata, vecs[i].err, vecs[i].addr,
               vecs[i].op == 2'b00, vecs[i].wdata);
      send_cmd(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].mask, vecs[i].er, vecs[i].es);
    end
    drain(400);
    chk("tbl_len_read3w", len_at(2), 4);

    // Wait-state timeout, followed by a normal read.
    len_q.delete();
    push_cfg(1000, 32'h0, 1'b0, 32'h30, 1'b0, 32'h0);
    push_cfg(0, 32'h55AA, 1'b0, 32'h34, 1'b0, 32'h0);
    send_cmd(2'b01, 32'h30, 32'h0, 32'h0, 32'h0, 2'b10);
    send_cmd(2'b01, 32'h34, 32'h0, 32'h0, 32'h55AA, 2'b00);
    drain(200);
    chk("to_access_len", len_at(0), 16);
    chk("to_next_len", len_at(1), 1);

    // Poll succeeding on the third read.
    x0 = xfer_cnt; idle_busy = 0;
    for (int i = 0; i < 3; i++) push_cfg(0, (i == 2) ? 32'h1 : 32'h0, 1'b0, 32'h8, 1'b0, 32'h0);
    send_cmd(2'b10, 32'h8, 32'h1, 32'h1, 32'h1, 2'b00);
    drain(200);
    chk("poll_ok_xfers", xfer_cnt - x0, 3);
    chk("poll_ok_idle_cycles", idle_busy, 3);

    // Poll exhausting POLL_MAX reads.
    x0 = xfer_cnt; idle_busy = 0;
    for (int i = 0; i < 4; i++) push_cfg(0, 32'h0, 1'b0, 32'h8, 1'b0, 32'h0);
    send_cmd(2'b10, 32'h8, 32'h1, 32'h1, 32'h0, 2'b11);
    drain(200);
    chk("poll_fail_xfers", xfer_cnt - x0, 4);
    chk("poll_fail_idle_cycles", idle_busy, 4);

    // Response back-pressure with eight queued reads.
    rsp_ready = 1'b0;
    x0 = xfer_cnt;
    for (int i = 0; i < 8; i++) begin
      push_cfg(0, 32'h1000 + i, 1'b0, 32'h200 + 4 * i, 1'b0, 32'h0);
      send_cmd(2'b01, 32'h200 + 4 * i, 32'h0, 32'h0, 32'h1000 + i, 2'b00);
    end
    repeat (20) @(posedge apb_clk);
    #1;
    chk("bp_cmd_ready", cmd_ready, 1'b0);
    chk("bp_xfers_stalled", xfer_cnt - x0, 4);
    chk("bp_state", {apb_psel, busy, rsp_valid}, 3'b011);
    rsp_ready = 1'b1;
    drain(300);
    chk("bp_xfers_total", xfer_cnt - x0, 8);

    // Reset in ACCESS with two commands still queued.
    push_cfg(10, 32'h1, 1'b0, 32'h300, 1'b0, 32'h0);
    push_cfg(0, 32'h2, 1'b0, 32'h304, 1'b0, 32'h0);
    push_cfg(0, 32'h3, 1'b0, 32'h308, 1'b0, 32'h0);
    send_cmd(2'b01, 32'h300, 32'h0, 32'h0, 32'h1, 2'b00);
    send_cmd(2'b01, 32'h304, 32'h0, 32'h0, 32'h2, 2'b00);
    send_cmd(2'b01, 32'h308, 32'h0, 32'h0, 32'h3, 2'b00);
    n = 0;
    while (!apb_penable && n < 20) begin
      @(posedge apb_clk); #1;
      n++;
    end
    chk("mid_rst_in_access", apb_penable, 1'b1);
    apb_reset = 1'b1;
    @(posedge apb_clk); #1;
    chk("mid_rst_sel_en", {apb_psel, apb_penable}, 2'b00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
    apb_reset = 1'b0;
    exp_q.delete();
    cfg_q.delete();
    x0 = rsp_seen;
    repeat (20) @(posedge apb_clk);
    #1;
    chk("mid_rst_no_rsp", rsp_seen - x0, 0);
    chk("mid_rst_idle", {busy, apb_psel}, 2'b00);

    // Recovery after reset.
    push_cfg(1, 32'hFACE_0001, 1'b0, 32'h40, 1'b0, 32'h0);
    send_cmd(2'b01, 32'h40, 32'h0, 32'h0, 32'hFACE_0001, 2'b00);
    drain(100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_total);
    $fatal(1);
  end
endmodule
